// File: rtl/cachepool_pkg.sv
// cachepool_pkg: shared types, defaults and helpers for the CachePool boot sequencer.
package cachepool_pkg;
  typedef enum logic [2:0] {IDLE, DELAY, REQ, RSP, WAKE, WAIT_EOC, DONE, FAIL} boot_state_e;
  typedef enum logic [1:0] {
    FAIL_NONE    = 2'b00,
    FAIL_TIMEOUT = 2'b01,
    FAIL_BUS_ERR = 2'b10
  } boot_fail_e;
  localparam logic [31:0] DefaultBootRegBase   = 32'h0000_0000;
  localparam logic [31:0] DefaultClusterStride = 32'h0010_0000;
  function automatic int unsigned idx_width(input int unsigned n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/cachepool_boot_find_next.sv
// cachepool_boot_find_next: lowest set bit of mask_i at or above from_i, with a found flag.
module cachepool_boot_find_next import cachepool_pkg::*; #(
  parameter int unsigned NumClusters = 4,
  localparam int unsigned IdxW = idx_width(NumClusters)
) (
  input  logic [NumClusters-1:0] mask_i,
  input  logic [IdxW:0]          from_i,
  output logic [IdxW-1:0]        idx_o,
  output logic                   valid_o
);
  always_comb begin
    idx_o = '0;
    valid_o = 1'b0;
    for (int i = NumClusters - 1; i >= 0; i--)
      if (mask_i[i] && i >= int'(from_i)) begin
        idx_o = IdxW'(i);
        valid_o = 1'b1;
      end
  end
endmodule

// File: rtl/cachepool_boot_sequencer.sv
// cachepool_boot_sequencer: writes the entry point into each enabled cluster's boot register,
// wakes the clusters and tracks end-of-computation, timeout and bus errors.
module cachepool_boot_sequencer import cachepool_pkg::*; #(
  parameter int unsigned NumClusters = 4,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter logic [AddrWidth-1:0] BootRegBase = AddrWidth'(DefaultBootRegBase),
  parameter logic [AddrWidth-1:0] ClusterStride = AddrWidth'(DefaultClusterStride),
  parameter int unsigned PreBootCycles = 1000,
  parameter int unsigned WakePulseCycles = 1,
  parameter int unsigned TimeoutWidth = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [AddrWidth-1:0]    entry_point_i,
  input  logic [NumClusters-1:0]  cluster_en_i,
  input  logic [TimeoutWidth-1:0] timeout_i,
  output logic                    q_valid_o,
  input  logic                    q_ready_i,
  output logic [AddrWidth-1:0]    q_addr_o,
  output logic [DataWidth-1:0]    q_data_o,
  output logic                    q_write_o,
  output logic [DataWidth/8-1:0]  q_strb_o,
  input  logic                    p_valid_i,
  input  logic                    p_error_i,
  output logic                    p_ready_o,
  output logic [NumClusters-1:0]  debug_req_o,
  input  logic [NumClusters-1:0]  eoc_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    fail_o,
  output logic [1:0]              fail_cause_o,
  output logic [NumClusters-1:0]  eoc_seen_o,
  output logic [TimeoutWidth-1:0] cycles_o
);
  localparam int unsigned IdxW = idx_width(NumClusters);
  boot_state_e state_q, state_d;
  boot_fail_e cause_q, cause_d;
  logic [NumClusters-1:0] en_q, en_d, eoc_seen_q, eoc_seen_d, fn_mask;
  logic [AddrWidth-1:0] entry_q, entry_d;
  logic [IdxW-1:0] idx_q, idx_d, fn_idx;
  logic [IdxW:0] fn_from;
  logic [31:0] cnt_q, cnt_d;
  logic [TimeoutWidth-1:0] cycles_q, cycles_d;
  logic accept, fn_valid;
  assign accept = start_i && (state_q == IDLE || state_q == DONE || state_q == FAIL);
  // On accept the search runs over the incoming mask from cluster 0, otherwise past idx.
  assign fn_mask = accept ? cluster_en_i : en_q;
  assign fn_from = accept ? '0 : (IdxW + 1)'(idx_q) + 1'b1;
  cachepool_boot_find_next #(.NumClusters(NumClusters)) u_find_next (
    .mask_i (fn_mask),
    .from_i (fn_from),
    .idx_o  (fn_idx),
    .valid_o(fn_valid)
  );
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    en_d = en_q;
    entry_d = entry_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    eoc_seen_d = eoc_seen_q;
    cycles_d = cycles_q;
    case (state_q)
      IDLE, DONE, FAIL: if (start_i) begin
        cause_d = FAIL_NONE;
        eoc_seen_d = '0;
        cycles_d = '0;
        en_d = cluster_en_i;
        entry_d = entry_point_i;
        idx_d = fn_idx;
        cnt_d = '0;
        state_d = cluster_en_i == '0 ? DONE : PreBootCycles == 0 ? REQ : DELAY;
      end
      DELAY: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == 32'(PreBootCycles - 1)) begin
          cnt_d = '0;
          state_d = REQ;
        end
      end
      REQ: state_d = q_ready_i ? RSP : REQ;
      RSP: if (p_valid_i) begin
        if (p_error_i) begin
          cause_d = FAIL_BUS_ERR;
          state_d = FAIL;
        end else if (fn_valid) begin
          idx_d = fn_idx;
          state_d = REQ;
        end else begin
          cnt_d = '0;
          state_d = WAKE;
        end
      end
      WAKE: begin
        eoc_seen_d = eoc_seen_q | (eoc_i & en_q);
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == 32'(WakePulseCycles - 1)) begin
          cnt_d = '0;
          state_d = WAIT_EOC;
        end
      end
      WAIT_EOC: begin
        eoc_seen_d = eoc_seen_q | (eoc_i & en_q);
        // Completion is tested first so it wins over a coinciding timeout.
        if ((eoc_seen_d & en_q) == en_q) state_d = DONE;
        else if (timeout_i != '0 && cycles_q == timeout_i - 1'b1) begin
          cause_d = FAIL_TIMEOUT;
          state_d = FAIL;
        end else cycles_d = cycles_q == '1 ? cycles_q : cycles_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cause_q <= FAIL_NONE;
      en_q <= '0;
      entry_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      eoc_seen_q <= '0;
      cycles_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      en_q <= en_d;
      entry_q <= entry_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      eoc_seen_q <= eoc_seen_d;
      cycles_q <= cycles_d;
    end
  end
  assign q_valid_o = state_q == REQ;
  assign q_addr_o = q_valid_o ? BootRegBase + AddrWidth'(idx_q) * ClusterStride : '0;
  assign q_data_o = q_valid_o ? DataWidth'(entry_q) : '0;
  assign q_write_o = q_valid_o;
  assign q_strb_o = {(DataWidth / 8){q_valid_o}};
  assign p_ready_o = state_q == RSP;
  assign debug_req_o = state_q == WAKE ? en_q : '0;
  assign busy_o = !(state_q == IDLE || state_q == DONE || state_q == FAIL);
  assign done_o = state_q == DONE;
  assign fail_o = state_q == FAIL;
  assign fail_cause_o = cause_q;
  assign eoc_seen_o = eoc_seen_q;
  assign cycles_o = cycles_q;
endmodule
